// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor duty sequencer.
package mtr_pkg;
  localparam int DUTY_W = 11;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;

  typedef enum logic [1:0] {RUN, RAMP_DN, DEAD} chan_st_t;

  // |spd| with -2048 saturated to the largest representable duty
  function automatic logic [DUTY_W-1:0] spd_mag(input logic [11:0] spd);
    logic [11:0] neg;
    neg = ~spd + 12'd1;
    if (!spd[11]) return spd[DUTY_W-1:0];
    if (neg[11]) return DUTY_MAX;
    return neg[DUTY_W-1:0];
  endfunction
endpackage

// File: rtl/mtr_chan_slew.sv
// One motor channel: slew-limited duty plus ramp-down / dead-period sequence on reversal.
module mtr_chan_slew
  import mtr_pkg::*;
#(
  parameter int SLEW      = 64,
  parameter int DEAD_PRDS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic              kill,
  input  logic              hold,
  input  logic              en,
  input  logic              tgt_rev,
  input  logic [DUTY_W-1:0] tgt_mag,
  output logic [DUTY_W-1:0] duty,
  output logic              rev
);
  localparam int DC_W = (DEAD_PRDS > 1) ? $clog2(DEAD_PRDS + 1) : 1;
  localparam logic [DUTY_W:0] S12 = (DUTY_W + 1)'(SLEW);

  chan_st_t          st, st_nxt;
  logic [DC_W-1:0]   dead_cnt, dead_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic              rev_nxt, eff_rev, ramp;
  logic [DUTY_W:0]   d12, m12, dn12, tw12;

  // one extra bit so the step compare never wraps
  always_comb begin
    eff_rev = en ? tgt_rev : rev;
    d12     = {1'b0, duty};
    m12     = en ? {1'b0, tgt_mag} : '0;
    dn12    = (d12 > S12) ? d12 - S12 : '0;
    if (m12 > d12)      tw12 = (m12 - d12 > S12) ? d12 + S12 : m12;
    else if (m12 < d12) tw12 = (d12 - m12 > S12) ? d12 - S12 : m12;
    else                tw12 = d12;
  end

  always_comb begin
    st_nxt   = st;
    duty_nxt = duty;
    rev_nxt  = rev;
    dead_nxt = dead_cnt;
    ramp     = 1'b0;
    if (kill) begin
      st_nxt   = RUN;
      duty_nxt = '0;
      dead_nxt = '0;
    end else if (upd && !hold) begin
      case (st)
        RUN: begin
          if (eff_rev == rev) duty_nxt = tw12[DUTY_W-1:0];
          else ramp = 1'b1;
        end
        RAMP_DN: ramp = 1'b1;
        DEAD: begin
          duty_nxt = '0;
          if (dead_cnt <= DC_W'(1)) begin
            dead_nxt = '0;
            rev_nxt  = eff_rev;
            st_nxt   = RUN;
          end else begin
            dead_nxt = dead_cnt - DC_W'(1);
          end
        end
        default: st_nxt = RUN;
      endcase
      if (ramp) begin
        duty_nxt = dn12[DUTY_W-1:0];
        if (dn12 == '0) begin
          st_nxt   = DEAD;
          dead_nxt = DC_W'(DEAD_PRDS);
        end else begin
          st_nxt = RAMP_DN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= RUN;
      duty     <= '0;
      rev      <= 1'b0;
      dead_cnt <= '0;
    end else begin
      st       <= st_nxt;
      duty     <= duty_nxt;
      rev      <= rev_nxt;
      dead_cnt <= dead_nxt;
    end
  end
endmodule

// File: rtl/mtr_duty_ctrl.sv
// Left/right PWM duty sequencer: period counter, target capture, over-current fault latch.
module mtr_duty_ctrl
  import mtr_pkg::*;
#(
  parameter int SLEW      = 64,
  parameter int DEAD_PRDS = 1,
  parameter int OVR_LIM   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              spd_vld,
  input  logic [11:0]       lft_spd,
  input  logic [11:0]       rght_spd,
  input  logic              ovr_i,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] lft_duty,
  output logic [DUTY_W-1:0] rght_duty,
  output logic              lft_rev,
  output logic              rght_rev,
  output logic              prd_strt,
  output logic              fault
);
  localparam int OVR_W = $clog2(OVR_LIM + 1);

  logic [DUTY_W-1:0] prd_cnt, lft_tgt_mag, rght_tgt_mag;
  logic              lft_tgt_rev, rght_tgt_rev;
  logic              upd, fault_set, fault_rel;
  logic [OVR_W-1:0]  ovr_cnt;

  assign upd       = (prd_cnt == DUTY_MAX);
  assign fault_set = ovr_i & ~fault & (ovr_cnt == OVR_W'(OVR_LIM - 1));
  assign fault_rel = fault & fault_clr & ~ovr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prd_cnt  <= '0;
      prd_strt <= 1'b0;
    end else begin
      prd_cnt  <= prd_cnt + 11'd1;
      prd_strt <= upd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      if (!ovr_i) ovr_cnt <= '0;
      else if (ovr_cnt != OVR_W'(OVR_LIM)) ovr_cnt <= ovr_cnt + OVR_W'(1);
      if (fault_set) fault <= 1'b1;
      else if (fault_rel) fault <= 1'b0;
    end
  end

  // on fault release the target direction follows the live direction so no reversal is queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_tgt_mag  <= '0;
      rght_tgt_mag <= '0;
      lft_tgt_rev  <= 1'b0;
      rght_tgt_rev <= 1'b0;
    end else if (fault_rel) begin
      lft_tgt_mag  <= '0;
      rght_tgt_mag <= '0;
      lft_tgt_rev  <= lft_rev;
      rght_tgt_rev <= rght_rev;
    end else if (spd_vld && !fault) begin
      lft_tgt_mag  <= spd_mag(lft_spd);
      rght_tgt_mag <= spd_mag(rght_spd);
      lft_tgt_rev  <= lft_spd[11];
      rght_tgt_rev <= rght_spd[11];
    end
  end

  mtr_chan_slew #(.SLEW(SLEW), .DEAD_PRDS(DEAD_PRDS)) u_lft (
    .clk     (clk),
    .rst     (rst),
    .upd     (upd),
    .kill    (fault_set),
    .hold    (fault),
    .en      (en),
    .tgt_rev (lft_tgt_rev),
    .tgt_mag (lft_tgt_mag),
    .duty    (lft_duty),
    .rev     (lft_rev)
  );

  mtr_chan_slew #(.SLEW(SLEW), .DEAD_PRDS(DEAD_PRDS)) u_rght (
    .clk     (clk),
    .rst     (rst),
    .upd     (upd),
    .kill    (fault_set),
    .hold    (fault),
    .en      (en),
    .tgt_rev (rght_tgt_rev),
    .tgt_mag (rght_tgt_mag),
    .duty    (rght_duty),
    .rev     (rght_rev)
  );
endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Directed bench for mtr_duty_ctrl; the right channel ramps to saturation alongside the left tests.
module tb_mtr_duty_ctrl;
  logic        clk = 1'b0;
  logic        rst, en, spd_vld, ovr_i, fault_clr;
  logic [11:0] lft_spd, rght_spd;
  logic [10:0] lft_duty, rght_duty;
  logic        lft_rev, rght_rev, prd_strt, fault;

  int checks = 0;
  int errors = 0;
  int prd_idx = 0;

  localparam logic [11:0] NEG_2048 = 12'h800;
  localparam logic [11:0] NEG_300  = 12'hED4;
  localparam logic [11:0] NEG_100  = 12'hF9C;
  localparam logic [11:0] NEG_50   = 12'hFCE;

  mtr_duty_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spd_vld   (spd_vld),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .ovr_i     (ovr_i),
    .fault_clr (fault_clr),
    .lft_duty  (lft_duty),
    .rght_duty (rght_duty),
    .lft_rev   (lft_rev),
    .rght_rev  (rght_rev),
    .prd_strt  (prd_strt),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // right channel after -2048 from reset: dead period, reversal, then 64/period up to 2047
  function automatic logic [10:0] exp_rght(input int k);
    int v;
    if (k <= 2) return 11'd0;
    v = 64 * (k - 2);
    if (v > 2047) v = 2047;
    return 11'(v);
  endfunction

  task automatic next_prd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!prd_strt && n < 2100);
    checks++;
    if (prd_strt !== 1'b1) begin
      errors++;
      $display("FAIL prd_timeout prd_strt=%b after %0d cycles, need 1", prd_strt, n);
    end
    prd_idx++;
  endtask

  task automatic send(input logic [11:0] l, input logic [11:0] r);
    spd_vld = 1'b1; lft_spd = l; rght_spd = r;
    @(negedge clk);
    spd_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; spd_vld = 1'b0; ovr_i = 1'b0; fault_clr = 1'b0;
    lft_spd = '0; rght_spd = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lft_duty, rght_duty, lft_rev, rght_rev, prd_strt, fault} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outs got %h, need 0", {lft_duty, rght_duty, lft_rev, rght_rev, prd_strt, fault});
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp_up;
    int n;
    logic [10:0] exp_l;
    send(12'd500, NEG_2048);
    for (int k = 1; k <= 8; k++) begin
      next_prd(n);
      if (k == 1) begin
        checks++;
        if (n !== 2047) begin
          errors++;
          $display("FAIL first_period got %0d cycles, need 2047", n);
        end
      end
      exp_l = (k * 64 > 500) ? 11'd500 : 11'(k * 64);
      checks++;
      if (lft_duty !== exp_l || lft_rev !== 1'b0) begin
        errors++;
        $display("FAIL ramp_up k=%0d got duty=%0d rev=%b, need %0d/0", k, lft_duty, lft_rev, exp_l);
      end
      checks++;
      if (rght_duty !== exp_rght(prd_idx) || rght_rev !== (prd_idx >= 2)) begin
        errors++;
        $display("FAIL rght_ramp k=%0d got duty=%0d rev=%b, need %0d/%b", prd_idx, rght_duty, rght_rev, exp_rght(prd_idx), prd_idx >= 2);
      end
    end
  endtask

  task automatic test_reversal;
    int n;
    logic [10:0] dn_d [5] = '{11'd436, 11'd372, 11'd308, 11'd244, 11'd200};
    logic [10:0] rv_d [7] = '{11'd136, 11'd72, 11'd8, 11'd0, 11'd0, 11'd64, 11'd100};
    logic        rv_r [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    send(12'd200, NEG_2048);
    for (int i = 0; i < 5; i++) begin
      next_prd(n);
      checks++;
      if (lft_duty !== dn_d[i] || lft_rev !== 1'b0) begin
        errors++;
        $display("FAIL slew_down i=%0d got %0d/%b, need %0d/0", i, lft_duty, lft_rev, dn_d[i]);
      end
    end
    send(NEG_100, NEG_2048);
    for (int i = 0; i < 7; i++) begin
      next_prd(n);
      checks++;
      if (lft_duty !== rv_d[i] || lft_rev !== rv_r[i]) begin
        errors++;
        $display("FAIL reversal i=%0d got %0d/%b, need %0d/%b", i, lft_duty, lft_rev, rv_d[i], rv_r[i]);
      end
      checks++;
      if (rght_duty !== exp_rght(prd_idx)) begin
        errors++;
        $display("FAIL rght_ramp k=%0d got %0d, need %0d", prd_idx, rght_duty, exp_rght(prd_idx));
      end
    end
  endtask

  // spd_vld lands on the update edge itself: the old target is used for that update
  task automatic test_upd_cycle_vld;
    int n;
    logic [10:0] exp_l;
    repeat (2047) @(negedge clk);
    send(NEG_300, NEG_2048);
    prd_idx++;
    checks++;
    if (prd_strt !== 1'b1 || lft_duty !== 11'd100) begin
      errors++;
      $display("FAIL upd_cycle_vld got strt=%b duty=%0d, need 1/100", prd_strt, lft_duty);
    end
    while (prd_idx < 35) begin
      next_prd(n);
      exp_l = (100 + 64 * (prd_idx - 21) > 300) ? 11'd300 : 11'(100 + 64 * (prd_idx - 21));
      checks++;
      if (lft_duty !== exp_l || lft_rev !== 1'b1) begin
        errors++;
        $display("FAIL new_tgt k=%0d got %0d/%b, need %0d/1", prd_idx, lft_duty, lft_rev, exp_l);
      end
      checks++;
      if (rght_duty !== exp_rght(prd_idx) || rght_rev !== 1'b1) begin
        errors++;
        $display("FAIL saturate k=%0d got %0d/%b, need %0d/1", prd_idx, rght_duty, rght_rev, exp_rght(prd_idx));
      end
    end
  endtask

  task automatic test_fault;
    int n;
    repeat (100) @(negedge clk);
    ovr_i = 1'b1;
    repeat (15) @(negedge clk);
    ovr_i = 1'b0;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || lft_duty !== 11'd300 || rght_duty !== 11'd2047) begin
      errors++;
      $display("FAIL ovr_15 got fault=%b duties=%0d/%0d, need 0/300/2047", fault, lft_duty, rght_duty);
    end
    ovr_i = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL ovr_early got fault=%b, need 0", fault);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || lft_duty !== 11'd0 || rght_duty !== 11'd0 || prd_strt !== 1'b0) begin
      errors++;
      $display("FAIL ovr_16 got fault=%b duties=%0d/%0d strt=%b, need 1/0/0/0", fault, lft_duty, rght_duty, prd_strt);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL clr_blocked got fault=%b, need 1", fault);
    end
    ovr_i = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || lft_rev !== 1'b1 || rght_rev !== 1'b1 || lft_duty !== 11'd0) begin
      errors++;
      $display("FAIL clr_ok got fault=%b rev=%b%b duty=%0d, need 0/11/0", fault, lft_rev, rght_rev, lft_duty);
    end
    next_prd(n);
    checks++;
    if (lft_duty !== 11'd0 || rght_duty !== 11'd0) begin
      errors++;
      $display("FAIL tgt_cleared got %0d/%0d, need 0/0", lft_duty, rght_duty);
    end
    send(NEG_100, NEG_50);
    next_prd(n);
    checks++;
    if (lft_duty !== 11'd64 || rght_duty !== 11'd50 || lft_rev !== 1'b1 || rght_rev !== 1'b1) begin
      errors++;
      $display("FAIL restart got %0d/%0d rev=%b%b, need 64/50/11", lft_duty, rght_duty, lft_rev, rght_rev);
    end
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_reversal;
    test_upd_cycle_vld;
    test_fault;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
